// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared constants and types for the UART transmitter.
//   - settings word layout (DELAYFRAMES, STOPBITS, PARITY, DATABITS)
//   - parity / stop-bit encodings
//   - one-hot FSM state type
//   - eff_databits(): maps the DATABITS field to the number of bits sent
package uart_tx_pkg;

    localparam int unsigned UartConfigWidthDelayframes = 16;
    localparam int unsigned UartConfigWidthStopbits    = 2;
    localparam int unsigned UartConfigWidthParity      = 2;
    localparam int unsigned UartConfigWidthDatabits    = 4;
    localparam int unsigned UartConfigWidth            = UartConfigWidthDelayframes +
                                                         UartConfigWidthStopbits +
                                                         UartConfigWidthParity +
                                                         UartConfigWidthDatabits;
    localparam int unsigned UartDataWidth              = 8;

    localparam logic [1:0] UartParityNone = 2'd0;
    localparam logic [1:0] UartParityOdd  = 2'd1;
    localparam logic [1:0] UartParityEven = 2'd2;

    localparam logic [1:0] UartStopbits1  = 2'd0;
    localparam logic [1:0] UartStopbits2  = 2'd1;

    // MSB..LSB: delayframes, stopbits, parity, databits
    typedef struct packed {
        logic [UartConfigWidthDelayframes-1:0] delayframes;
        logic [UartConfigWidthStopbits-1:0]    stopbits;
        logic [UartConfigWidthParity-1:0]      parity;
        logic [UartConfigWidthDatabits-1:0]    databits;
    } uart_settings_t;

    typedef enum logic [4:0] {
        StIdle   = 5'b00001,
        StStart  = 5'b00010,
        StData   = 5'b00100,
        StParity = 5'b01000,
        StStop   = 5'b10000
    } uart_tx_state_e;

    // 0 or anything wider than the data path means "full width".
    function automatic int unsigned eff_databits(
        input logic [UartConfigWidthDatabits-1:0] field,
        input int unsigned                        data_width
    );
        int unsigned f;
        f = 32'(field);
        if (f == 0 || f > data_width) begin
            return data_width;
        end
        return f;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: client <-> transmitter bundle.
//   ce            clock enable for the bit timer
//   datain        word to send
//   uart_tx_start send request
//   uart_tx_ready transmitter idle
//   uart_tx_done  one-cycle pulse at end of last stop bit
//   uart_txpin    serial line (idle high)
//   settings      runtime frame format / bit period
// master = client side, slave = transmitter side.
interface uart_tx_if
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UartDataWidth
) ();

    logic                       ce;
    logic [DATA_WIDTH-1:0]      datain;
    logic                       uart_tx_start;
    logic                       uart_tx_ready;
    logic                       uart_tx_done;
    logic                       uart_txpin;
    logic [UartConfigWidth-1:0] settings;

    modport master (
        output ce, datain, uart_tx_start, settings,
        input  uart_tx_ready, uart_tx_done, uart_txpin
    );

    modport slave (
        input  ce, datain, uart_tx_start, settings,
        output uart_tx_ready, uart_tx_done, uart_txpin
    );

endinterface

// File: rtl/counter_with_strobe.sv
// counter_with_strobe: bit-period timer.
//   clk, rst (async, active-high), ce, reset_value, strobe
// Counts ce-qualified clocks from 0; strobe marks the ce cycle in which the
// count reaches reset_value, giving a period of reset_value+1 ce cycles.
// With LATENCY > 0 the strobe is delayed by that many clocks.
module counter_with_strobe #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] reset_value,
    output logic             strobe
);

    logic [WIDTH-1:0] count_q;
    logic             hit;

    assign hit = ce && (count_q == reset_value);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (ce) begin
            count_q <= hit ? '0 : count_q + 1'b1;
        end
    end

    if (LATENCY == 0) begin : g_direct
        assign strobe = hit;
    end else begin : g_pipe
        logic [LATENCY-1:0] pipe_q;
        logic [LATENCY:0]   pipe_ext;
        assign pipe_ext = {pipe_q, hit};
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_ext[LATENCY-1:0];
            end
        end
        assign strobe = pipe_q[LATENCY-1];
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Sends start bit, LSB-first data, optional
// parity and 1 or 2 stop bits, one word per accepted request.
//   clk, rst   clock, asynchronous active-high reset
//   bus        uart_tx_if.slave (ce, datain, uart_tx_start, uart_tx_ready,
//              uart_tx_done, uart_txpin, settings)
// Optional feature: define UART_TX_PARITY_EN to build the parity bit.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = UartConfigWidthDelayframes,
    parameter int unsigned DATA_WIDTH    = UartDataWidth,
    parameter int unsigned LATENCY       = 0
) (
    input logic      clk,
    input logic      rst,
    uart_tx_if.slave bus
);

    localparam int unsigned CntWidth = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned IdxIdle  = 0;

    uart_tx_state_e         state_q;
    logic                   txpin_q;
    logic                   ready_q;
    logic                   done_q;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic [COUNTER_WIDTH-1:0] delay_q;
    logic [1:0]             stop_mode_q;
    logic [CntWidth-1:0]    bits_left_q;
    logic                   stop_left_q;

    uart_settings_t         cfg_in;
    logic [DATA_WIDTH-1:0]  shift_next;
    logic [CntWidth-1:0]    first_cnt;
    logic [4:0]             state_bits;
    logic                   timer_rst;
    logic                   strobe;

    assign cfg_in     = bus.settings;
    assign shift_next = shift_q >> 1;
    assign first_cnt  = CntWidth'(eff_databits(cfg_in.databits, DATA_WIDTH) - 1);
    assign state_bits = state_q;
    // Timer sits in reset while idle so each frame starts a fresh bit period.
    assign timer_rst  = state_bits[IdxIdle];

`ifdef UART_TX_PARITY_EN
    logic       parity_acc_q;
    logic [1:0] parity_mode_q;
    logic       par_en;
    logic       par_bit;
    assign par_en  = (parity_mode_q == UartParityOdd) || (parity_mode_q == UartParityEven);
    // Last data bit is folded in here because the accumulator lags by one bit.
    assign par_bit = parity_acc_q ^ shift_q[0] ^ (parity_mode_q == UartParityOdd);
`else
    logic unused_parity;
    assign unused_parity = ^cfg_in.parity;
`endif

    counter_with_strobe #(
        .WIDTH  (COUNTER_WIDTH),
        .LATENCY(LATENCY)
    ) u_timer (
        .clk        (clk),
        .rst        (timer_rst),
        .ce         (bus.ce),
        .reset_value(delay_q),
        .strobe     (strobe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            txpin_q       <= 1'b1;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            shift_q       <= '0;
            delay_q       <= '0;
            stop_mode_q   <= UartStopbits1;
            bits_left_q   <= '0;
            stop_left_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_acc_q  <= 1'b0;
            parity_mode_q <= UartParityNone;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.uart_tx_start && ready_q) begin
                        state_q       <= StStart;
                        txpin_q       <= 1'b0;
                        ready_q       <= 1'b0;
                        shift_q       <= bus.datain;
                        delay_q       <= COUNTER_WIDTH'(cfg_in.delayframes);
                        stop_mode_q   <= cfg_in.stopbits;
                        bits_left_q   <= first_cnt;
`ifdef UART_TX_PARITY_EN
                        parity_acc_q  <= 1'b0;
                        parity_mode_q <= cfg_in.parity;
`endif
                    end
                end
                StStart: begin
                    if (strobe) begin
                        state_q <= StData;
                        txpin_q <= shift_q[0];
                    end
                end
                StData: begin
                    if (strobe) begin
`ifdef UART_TX_PARITY_EN
                        parity_acc_q <= parity_acc_q ^ shift_q[0];
`endif
                        if (bits_left_q == '0) begin
                            stop_left_q <= (stop_mode_q != UartStopbits1);
`ifdef UART_TX_PARITY_EN
                            if (par_en) begin
                                state_q <= StParity;
                                txpin_q <= par_bit;
                            end else begin
                                state_q <= StStop;
                                txpin_q <= 1'b1;
                            end
`else
                            state_q <= StStop;
                            txpin_q <= 1'b1;
`endif
                        end else begin
                            shift_q     <= shift_next;
                            txpin_q     <= shift_next[0];
                            bits_left_q <= bits_left_q - 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (strobe) begin
                        state_q <= StStop;
                        txpin_q <= 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (strobe) begin
                        if (stop_left_q) begin
                            stop_left_q <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    txpin_q <= 1'b1;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.uart_txpin    = txpin_q;
    assign bus.uart_tx_ready = ready_q;
    assign bus.uart_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. Table of frame formats plus
// hand-written back-to-back and mid-frame reset sequences. Expected line
// bits are pushed to a queue at request time and popped as bits complete.
module tb_uart_tx;
    import uart_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_tx_if #(.DATA_WIDTH(8)) bus ();

    uart_tx #(
        .COUNTER_WIDTH(16),
        .DATA_WIDTH   (8),
        .LATENCY      (0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

`ifdef UART_TX_PARITY_EN
    localparam int ParBit = 1;
`else
    localparam int ParBit = 0;
`endif

    typedef struct {
        int         delay;
        int         databits;
        int         parity;
        int         stop;
        logic [7:0] data;
        int         ce_div;
        int         poke;
        int         len;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   ce_div = 1;
    int   ph = 0;
    logic exp_q[$];

    // ce generator: changes shortly after posedge, so it is stable at negedge.
    initial begin
        bus.ce = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ph = (ph + 1) % ce_div;
            bus.ce = (ph == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic uart_settings_t mk(input int delay, input int db, input int par,
                                          input int stop);
        uart_settings_t s;
        s.delayframes = 16'(delay);
        s.databits    = 4'(db);
        s.parity      = 2'(par);
        s.stopbits    = 2'(stop);
        return s;
    endfunction

    function automatic void push_frame(input uart_settings_t s, input logic [7:0] d);
        int   n;
        logic p;
        n = (s.databits == 0 || s.databits > 8) ? 8 : int'(s.databits);
        exp_q.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (ParBit == 1 && (s.parity == 2'd1 || s.parity == 2'd2)) begin
            exp_q.push_back((s.parity == 2'd1) ? ~p : p);
        end
        exp_q.push_back(1'b1);
        if (s.stopbits != UartStopbits1) exp_q.push_back(1'b1);
    endfunction

    // Call at a negedge; returns at the negedge where done should be high.
    task automatic run_frame(input uart_settings_t s, input logic [7:0] d, input int poke,
                             input int cediv, output int clocks);
        int   bitn;
        int   ce_cnt;
        int   bit_clk;
        logic cur;
        logic ok;
        bus.settings      = s;
        bus.datain        = d;
        bus.uart_tx_start = 1'b1;
        push_frame(s, d);
        @(posedge clk);
        #1;
        bus.uart_tx_start = 1'b0;
        bus.datain        = ~d;
        bus.settings      = ~s;
        clocks  = 0;
        bitn    = 0;
        ce_cnt  = 0;
        bit_clk = 0;
        cur     = exp_q.pop_front();
        ok      = 1'b1;
        while (1) begin
            @(negedge clk);
            clocks++;
            bit_clk++;
            if (clocks > 5000) begin
                bad++;
                total++;
                $display("FAIL timeout: got no frame end want done within 5000 clocks");
                exp_q.delete();
                return;
            end
            if (bus.uart_txpin !== cur || bus.uart_tx_ready !== 1'b0 ||
                bus.uart_tx_done !== 1'b0) ok = 1'b0;
            bus.uart_tx_start = (poke > 0 && bitn == poke && bit_clk == 1);
            if (bus.ce) ce_cnt++;
            if (ce_cnt == s.delayframes + 1) begin
                check($sformatf("bit%0d_level(exp %0b)", bitn, cur), 32'(ok), 32'd1);
                if (cediv == 1 || bitn > 0) begin
                    check($sformatf("bit%0d_clocks", bitn), bit_clk,
                          (int'(s.delayframes) + 1) * cediv);
                end
                bitn++;
                if (exp_q.size() == 0) break;
                cur     = exp_q.pop_front();
                ok      = 1'b1;
                ce_cnt  = 0;
                bit_clk = 0;
            end
        end
        bus.uart_tx_start = 1'b0;
        @(negedge clk);
        check("done_pulse{pin,ready,done}",
              {29'd0, bus.uart_txpin, bus.uart_tx_ready, bus.uart_tx_done}, 32'b111);
    endtask

    task automatic check_idle(input string name);
        repeat (3) @(negedge clk);
        check(name, {29'd0, bus.uart_txpin, bus.uart_tx_ready, bus.uart_tx_done}, 32'b110);
    endtask

    vec_t vecs[8];
    int   clocks;
    logic seen_done;

    initial begin
        vecs[0] = '{3, 8, 0, 0, 8'hA5, 1, 0, 10};
        vecs[1] = '{2, 8, 2, 0, 8'h03, 1, 0, 10 + ParBit};
        vecs[2] = '{2, 8, 1, 0, 8'h03, 1, 0, 10 + ParBit};
        vecs[3] = '{1, 7, 0, 1, 8'hFF, 1, 3, 10};
        vecs[4] = '{1, 8, 0, 0, 8'h5A, 3, 0, 10};
        vecs[5] = '{0, 0, 3, 0, 8'h81, 1, 0, 10};
        vecs[6] = '{0, 12, 0, 1, 8'h3C, 1, 0, 11};
        vecs[7] = '{2, 5, 2, 0, 8'h16, 1, 0, 7 + ParBit};

        bus.uart_tx_start = 1'b0;
        bus.datain        = '0;
        bus.settings      = '0;
        #1 rst = 1'b1;
        #1;
        check("reset{pin,ready,done}",
              {29'd0, bus.uart_txpin, bus.uart_tx_ready, bus.uart_tx_done}, 32'b110);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            ce_div = vecs[i].ce_div;
            @(negedge clk);
            run_frame(mk(vecs[i].delay, vecs[i].databits, vecs[i].parity, vecs[i].stop),
                      vecs[i].data, vecs[i].poke, vecs[i].ce_div, clocks);
            if (vecs[i].ce_div == 1) begin
                check($sformatf("vec%0d_frame_clocks", i), clocks,
                      vecs[i].len * (vecs[i].delay + 1));
            end
            check_idle($sformatf("vec%0d_idle_after", i));
        end
        ce_div = 1;

        // Back-to-back: second request issued in the done cycle.
        @(negedge clk);
        run_frame(mk(1, 8, 0, 0), 8'h96, 0, 1, clocks);
        run_frame(mk(1, 8, 0, 0), 8'h69, 0, 1, clocks);
        check("b2b_second_clocks", clocks, 20);
        check_idle("b2b_idle_after");

        // Reset in the middle of data bit 4.
        @(negedge clk);
        bus.settings      = mk(3, 8, 0, 0);
        bus.datain        = 8'hA5;
        bus.uart_tx_start = 1'b1;
        @(posedge clk);
        #1 bus.uart_tx_start = 1'b0;
        repeat (22) @(negedge clk);
        check("midframe_bit4_low", {31'd0, bus.uart_txpin}, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("async_reset{pin,ready,done}",
              {29'd0, bus.uart_txpin, bus.uart_tx_ready, bus.uart_tx_done}, 32'b110);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (bus.uart_tx_done !== 1'b0 || bus.uart_txpin !== 1'b1) seen_done = 1'b1;
        end
        check("no_done_after_abort", {31'd0, seen_done}, 32'd0);
        run_frame(mk(3, 8, 0, 0), 8'hC3, 0, 1, clocks);
        check("post_reset_frame_clocks", clocks, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
